ysyx_24100006_key_lut_reg: RTL and testbench
============================================

// Module: ysyx_24100006_key_lut_reg
// PURPOSE
//  Programmable, registered key->data lookup table; sequential successor of the combinational key mux.
//  NR_KEY entries {valid, key, data} are written at run time and searched in parallel.
//  One-cycle-latency lookup with valid/ready on both sides, hit flag, matched index and default fallback.
//  Used by decode/CSR paths that need a reconfigurable opcode->control map without re-synthesis.
// PARAMETERS
//  NR_KEY    8   number of table entries (>=2)
//  KEY_LEN   7   key width in bits
//  DATA_LEN  32  data width in bits
//  IDX_W     derived localparam = clog2(NR_KEY); not overridable
// PORTS
//  clk           in   1         clock, all state on rising edge
//  rst           in   1         asynchronous, active-high reset
//  wr_en         in   1         write entry wr_idx this cycle
//  wr_idx        in   IDX_W     entry index; values >= NR_KEY ignored
//  wr_key        in   KEY_LEN   key to store
//  wr_data       in   DATA_LEN  data to store
//  flush         in   1         clear all entry valid bits
//  default_data  in   DATA_LEN  returned on miss (sampled with request)
//  req_valid     in   1         lookup request present
//  req_ready     out  1         request accepted when req_valid & req_ready
//  req_key       in   KEY_LEN   key to look up
//  rsp_valid     out  1         response present
//  rsp_ready     in   1         consumer takes response
//  rsp_data      out  DATA_LEN  matched data or default_data
//  rsp_hit       out  1         1 = some valid entry matched
//  rsp_idx       out  IDX_W     lowest matching index; 0 on miss
// BEHAVIOUR
//  - Reset: all entry valid bits 0, rsp_valid 0, rsp_data 0, rsp_hit 0, rsp_idx 0; keys/data need no reset.
//  - req_ready = !rsp_valid | rsp_ready (combinational; one output register, no bubble under back-pressure).
//  - Accept (req_valid & req_ready) at edge N: match computed on table state *before* edge N;
//    rsp_* loaded at edge N, rsp_valid=1 from cycle N+1. Latency exactly 1 cycle.
//  - rsp_valid & !rsp_ready: rsp_* held stable, no new accept; dropping req_valid allowed.
//  - rsp_ready & no accept: rsp_valid clears at the edge.
//  - Match: entry i hits when valid[i] & key[i]==req_key. Multiple hits -> lowest i wins (priority),
//    never OR of data. No hit -> rsp_data=default_data, rsp_hit=0, rsp_idx=0.
//  - Write: wr_en sets valid[wr_idx]=1, key/data overwritten at edge; wr_idx>=NR_KEY is a no-op.
//  - Same-cycle write + accept, same entry: lookup sees OLD contents (read-before-write).
//  - flush: all valid cleared at edge; flush & wr_en same cycle -> flush first, written entry ends valid.
//    Lookup accepted in the flush cycle still sees pre-flush table. Pending rsp_* not affected by flush.
//  - rst asserted mid-transaction: in-flight response discarded immediately (rsp_valid->0 asynchronously).
//  - No FSM beyond the rsp_valid bit; table state is NR_KEY*(1+KEY_LEN+DATA_LEN) flops.
// STRUCTURE
//  - Shared header ysyx_24100006_defs.vh: CLOG2 macro used for IDX_W.
//  - Sub-module ysyx_24100006_prio_enc #(N): N-bit hit vector -> {any, lowest index}; reused elsewhere.
//  - Top: entry array + write logic, parallel comparators, prio_enc, data mux by index, rsp register.
// TESTING (NR_KEY=8, KEY_LEN=7, DATA_LEN=32 unless stated)
//  1 reset then lookup key 7'h33, default 32'hDEAD -> cycle+1 rsp_valid=1, hit=0, data=32'hDEAD, idx=0
//  2 write idx3 {7'h13, 32'h1111}, next cycle lookup 7'h13 -> hit=1, idx=3, data=32'h1111
//  3 idx2 and idx5 both key 7'h23 (data A/B) -> lookup returns idx=2, data=A
//  4 write idx3 {7'h13,32'h2222} same cycle as lookup 7'h13 -> response 32'h1111; next lookup 32'h2222
//  5 rsp_ready=0 for 4 cycles with req_valid=1 -> req_ready=0, rsp_* stable, one accept after release
//  6 flush then lookup 7'h13 -> hit=0; rst pulse while rsp_valid=1 -> rsp_valid=0 at once; wr_idx=9 (NR_KEY=9 build, IDX_W=4, idx 9..15 no-op)

Source files
------------

// File: rtl/ysyx_24100006_key_lut_reg_pkg.sv
// Shared constants and helpers for the registered key->data lookup table.
package ysyx_24100006_key_lut_reg_pkg;

  localparam int DefNrKey   = 8;
  localparam int DefKeyLen  = 7;
  localparam int DefDataLen = 32;

  // Index width for an N-entry table; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ysyx_24100006_key_lut_reg_prio_enc.sv
// Priority encoder: N-bit hit vector -> {any hit, lowest set index}.
module ysyx_24100006_prio_enc
  import ysyx_24100006_key_lut_reg_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idxWidth(N)
) (
  input  logic [N-1:0] i_hits,
  output logic         o_any,
  output logic [W-1:0] o_idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_any = |i_hits;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_hits[i]) begin
        o_idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/ysyx_24100006_key_lut_reg.sv
// Programmable key->data lookup table with a one-cycle registered response
// and valid/ready handshakes on the request and response sides.
module ysyx_24100006_key_lut_reg
  import ysyx_24100006_key_lut_reg_pkg::*;
#(
  parameter  int NR_KEY   = DefNrKey,
  parameter  int KEY_LEN  = DefKeyLen,
  parameter  int DATA_LEN = DefDataLen,
  localparam int IDX_W    = idxWidth(NR_KEY)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [KEY_LEN-1:0]  i_wr_key,
  input  logic [DATA_LEN-1:0] i_wr_data,
  input  logic                i_flush,
  input  logic [DATA_LEN-1:0] i_default_data,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [KEY_LEN-1:0]  i_req_key,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_LEN-1:0] o_rsp_data,
  output logic                o_rsp_hit,
  output logic [IDX_W-1:0]    o_rsp_idx
);

  localparam logic [IDX_W:0] NrKeyW = (IDX_W + 1)'(NR_KEY);

  logic [NR_KEY-1:0]   r_valid;
  logic [KEY_LEN-1:0]  r_key  [NR_KEY];
  logic [DATA_LEN-1:0] r_data [NR_KEY];

  logic                r_rspValid;
  logic [DATA_LEN-1:0] r_rspData;
  logic                r_rspHit;
  logic [IDX_W-1:0]    r_rspIdx;

  logic                w_wrFire;
  logic [NR_KEY-1:0]   w_validNext;
  logic [NR_KEY-1:0]   w_hits;
  logic                w_hitAny;
  logic [IDX_W-1:0]    w_hitIdx;
  logic [DATA_LEN-1:0] w_hitData;
  logic                w_accept;

  assign w_wrFire = i_wr_en && ({1'b0, i_wr_idx} < NrKeyW);

  // Flush clears first, so an entry written in the same cycle survives.
  always_comb begin
    w_validNext = r_valid;
    if (i_flush) begin
      w_validNext = '0;
    end
    for (int i = 0; i < NR_KEY; i++) begin
      if (w_wrFire && (i_wr_idx == IDX_W'(i))) begin
        w_validNext[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_validNext;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NR_KEY; i++) begin
      if (w_wrFire && (i_wr_idx == IDX_W'(i))) begin
        r_key[i]  <= i_wr_key;
        r_data[i] <= i_wr_data;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NR_KEY; i++) begin
      w_hits[i] = r_valid[i] && (r_key[i] == i_req_key);
    end
  end

  ysyx_24100006_prio_enc #(
    .N(NR_KEY),
    .W(IDX_W)
  ) u_prioEnc (
    .i_hits(w_hits),
    .o_any (w_hitAny),
    .o_idx (w_hitIdx)
  );

  always_comb begin
    w_hitData = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (w_hitIdx == IDX_W'(i)) begin
        w_hitData = r_data[i];
      end
    end
  end

  assign o_req_ready = !r_rspValid || i_rsp_ready;
  assign w_accept    = i_req_valid && o_req_ready;

  // Single output register: reloads on accept, otherwise drains when taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspHit   <= 1'b0;
      r_rspIdx   <= '0;
    end else if (w_accept) begin
      r_rspValid <= 1'b1;
      r_rspData  <= w_hitAny ? w_hitData : i_default_data;
      r_rspHit   <= w_hitAny;
      r_rspIdx   <= w_hitAny ? w_hitIdx : '0;
    end else if (i_rsp_ready) begin
      r_rspValid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rspValid;
  assign o_rsp_data  = r_rspData;
  assign o_rsp_hit   = r_rspHit;
  assign o_rsp_idx   = r_rspIdx;

endmodule

// File: tb/tb_ysyx_24100006_key_lut_reg.sv
// Scoreboard bench for the registered key lookup table (8-entry and 9-entry builds).
module tb_ysyx_24100006_key_lut_reg;

  localparam int NrKey = 8;
  localparam int NrKeyB = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wrEn, flush, reqValid, reqReady, rspValid, rspReady, rspHit;
  logic [2:0]  wrIdx, rspIdx;
  logic [6:0]  wrKey, reqKey;
  logic [31:0] wrData, dflt, rspData;

  logic        bWrEn, bReqValid, bReqReady, bRspValid, bRspHit;
  logic        bFlush, bRspReady;
  logic [3:0]  bWrIdx, bRspIdx;
  logic [6:0]  bWrKey, bReqKey;
  logic [31:0] bWrData, bDflt, bRspData;

  ysyx_24100006_key_lut_reg dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wrEn), .i_wr_idx(wrIdx),
    .i_wr_key(wrKey), .i_wr_data(wrData), .i_flush(flush),
    .i_default_data(dflt), .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_key(reqKey), .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
    .o_rsp_data(rspData), .o_rsp_hit(rspHit), .o_rsp_idx(rspIdx)
  );

  ysyx_24100006_key_lut_reg #(.NR_KEY(NrKeyB)) dutB (
    .i_clk(clk), .i_rst(rst), .i_wr_en(bWrEn), .i_wr_idx(bWrIdx),
    .i_wr_key(bWrKey), .i_wr_data(bWrData), .i_flush(bFlush),
    .i_default_data(bDflt), .i_req_valid(bReqValid), .o_req_ready(bReqReady),
    .i_req_key(bReqKey), .o_rsp_valid(bRspValid), .i_rsp_ready(bRspReady),
    .o_rsp_data(bRspData), .o_rsp_hit(bRspHit), .o_rsp_idx(bRspIdx)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        hit;
    logic [3:0]  idx;
  } rsp_t;

  rsp_t expQ[$];
  rsp_t monExp;
  bit   pendA;
  bit   monOn;
  int   testCount;
  int   failCount;

  bit          mValid [NrKey];
  logic [6:0]  mKey   [NrKey];
  logic [31:0] mData  [NrKey];
  bit          bValidM[NrKeyB];
  logic [6:0]  bKeyM  [NrKeyB];
  logic [31:0] bDataM [NrKeyB];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // First valid entry whose key matches wins; otherwise the default is returned.
  function automatic rsp_t refLookupA(input logic [6:0] k, input logic [31:0] d);
    rsp_t r;
    r = '{data: d, hit: 1'b0, idx: 4'd0};
    for (int i = 0; i < NrKey; i++) begin
      if (mValid[i] && mKey[i] == k) begin
        r = '{data: mData[i], hit: 1'b1, idx: 4'(i)};
        break;
      end
    end
    return r;
  endfunction

  function automatic rsp_t refLookupB(input logic [6:0] k, input logic [31:0] d);
    rsp_t r;
    r = '{data: d, hit: 1'b0, idx: 4'd0};
    for (int i = 0; i < NrKeyB; i++) begin
      if (bValidM[i] && bKeyM[i] == k) begin
        r = '{data: bDataM[i], hit: 1'b1, idx: 4'(i)};
        break;
      end
    end
    return r;
  endfunction

  // Monitor: every presented response must equal the oldest expected one.
  always @(negedge clk) begin
    if (monOn && !rst) begin
      checkOutput("rsp_valid", 64'(rspValid), 64'(pendA));
      if (rspValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          monExp = expQ[0];
          checkOutput("rsp_data", 64'(rspData), 64'(monExp.data));
          checkOutput("rsp_hit", 64'(rspHit), 64'(monExp.hit));
          checkOutput("rsp_idx", 64'(rspIdx), 64'(monExp.idx));
          if (rspReady) begin
            void'(expQ.pop_front());
          end
        end
      end
    end
  end

  // One clock of stimulus on the 8-entry table; the model advances after the edge.
  task automatic applyStimulus(input bit we, input int wi, input logic [6:0] wk,
                               input logic [31:0] wd, input bit fl, input bit rv,
                               input logic [6:0] rk, input logic [31:0] df, input bit rr);
    bit rdy;
    bit acc;
    wrEn = we; wrIdx = 3'(wi); wrKey = wk; wrData = wd; flush = fl;
    reqValid = rv; reqKey = rk; dflt = df; rspReady = rr;
    #1;
    rdy = !pendA || rr;
    checkOutput("req_ready", 64'(reqReady), 64'(rdy));
    acc = rv && rdy;
    if (acc) expQ.push_back(refLookupA(rk, df));
    @(posedge clk);
    #1;
    if (fl) begin
      for (int i = 0; i < NrKey; i++) mValid[i] = 1'b0;
    end
    if (we && wi < NrKey) begin
      mValid[wi] = 1'b1; mKey[wi] = wk; mData[wi] = wd;
    end
    pendA = acc ? 1'b1 : (rr ? 1'b0 : pendA);
  endtask

  // One clock on the 9-entry table, always ready for the response.
  task automatic bStep(input bit we, input int wi, input logic [6:0] wk,
                       input logic [31:0] wd, input bit rv, input logic [6:0] rk);
    rsp_t e;
    bWrEn = we; bWrIdx = 4'(wi); bWrKey = wk; bWrData = wd;
    bReqValid = rv; bReqKey = rk;
    e = refLookupB(rk, bDflt);
    @(posedge clk);
    #1;
    if (we && wi < NrKeyB) begin
      bValidM[wi] = 1'b1; bKeyM[wi] = wk; bDataM[wi] = wd;
    end
    checkOutput("b_rsp_valid", 64'(bRspValid), 64'(rv));
    if (rv) begin
      checkOutput("b_rsp_data", 64'(bRspData), 64'(e.data));
      checkOutput("b_rsp_hit", 64'(bRspHit), 64'(e.hit));
      checkOutput("b_rsp_idx", 64'(bRspIdx), 64'(e.idx));
    end
  endtask

  initial begin
    testCount = 0; failCount = 0; monOn = 1'b0; pendA = 1'b0;
    for (int i = 0; i < NrKey; i++) mValid[i] = 1'b0;
    for (int i = 0; i < NrKeyB; i++) bValidM[i] = 1'b0;
    rst = 1'b1;
    wrEn = 0; wrIdx = 0; wrKey = 0; wrData = 0; flush = 0; dflt = 0;
    reqValid = 0; reqKey = 0; rspReady = 1;
    bWrEn = 0; bWrIdx = 0; bWrKey = 0; bWrData = 0; bFlush = 0; bDflt = 32'hB0B0;
    bReqValid = 0; bReqKey = 0; bRspReady = 1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
    checkOutput("reset_rsp_data", 64'(rspData), 64'd0);
    checkOutput("reset_rsp_hit", 64'(rspHit), 64'd0);
    checkOutput("reset_rsp_idx", 64'(rspIdx), 64'd0);
    checkOutput("reset_b_rsp_valid", 64'(bRspValid), 64'd0);
    rst = 1'b0;

    // 9-entry build: indices 9..15 must be ignored, index 8 usable.
    for (int i = 9; i < 16; i++) bStep(1, i, 7'h55, 32'(i), 0, 7'h0);
    bStep(0, 0, 7'h0, 32'h0, 1, 7'h55);
    bStep(1, 8, 7'h55, 32'h88, 0, 7'h0);
    bStep(0, 0, 7'h0, 32'h0, 1, 7'h55);
    bStep(1, 0, 7'h55, 32'h10, 0, 7'h0);
    bStep(0, 0, 7'h0, 32'h0, 1, 7'h55);
    bStep(0, 0, 7'h0, 32'h0, 0, 7'h0);

    monOn = 1'b1;
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h33, 32'hDEAD, 1);
    applyStimulus(1, 3, 7'h13, 32'h1111, 0, 0, 7'h00, 32'hDEAD, 1);
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h13, 32'hDEAD, 1);
    applyStimulus(1, 2, 7'h23, 32'hAAAA, 0, 0, 7'h00, 32'hDEAD, 1);
    applyStimulus(1, 5, 7'h23, 32'hBBBB, 0, 0, 7'h00, 32'hDEAD, 1);
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h23, 32'hDEAD, 1);
    applyStimulus(1, 3, 7'h13, 32'h2222, 0, 1, 7'h13, 32'hDEAD, 1);
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h13, 32'hDEAD, 1);

    applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h23, 32'hDEAD, 1);
    repeat (4) applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h13, 32'hBEEF, 0);
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h13, 32'hBEEF, 1);
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0, 1);

    applyStimulus(0, 0, 7'h00, 32'h0, 1, 1, 7'h13, 32'hDEAD, 1);
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h13, 32'hDEAD, 1);
    applyStimulus(1, 1, 7'h44, 32'h4444, 1, 0, 7'h00, 32'h0, 1);
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h44, 32'hDEAD, 1);
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0, 1);

    // Hold a response, then reset underneath it.
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h44, 32'hDEAD, 0);
    checkOutput("rsp_pending_before_rst", 64'(rspValid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_rsp_valid", 64'(rspValid), 64'd0);
    expQ.delete();
    pendA = 1'b0;
    for (int i = 0; i < NrKey; i++) mValid[i] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 0, 7'h00, 32'h0, 0, 1, 7'h44, 32'hCAFE, 1);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom % 3) == 0, int'($urandom % NrKey), 7'($urandom % 8),
                    $urandom, ($urandom % 23) == 0, ($urandom % 4) != 0,
                    7'($urandom % 8), $urandom, ($urandom % 4) != 0);
    end
    repeat (3) applyStimulus(0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0, 1);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
